// File: rtl/life_grid_engine.sv
`default_nettype none
// ============================================================================
//  Module      : life_grid_engine
//  Description : Conway's Game of Life (B3/S23) engine on a ROWS x COLS grid.
//                Supports single-stepping, timed free-running, and optionally
//                halting when the pattern stops changing. Edges can be
//                toroidal or read as dead.
//  Revision    : 1.0 - initial release
// ============================================================================
module life_grid_engine #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int WRAP   = 1,
    parameter int PERIOD = 100000000,
    parameter int GEN_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   write_enb,
    input  logic [ROWS*COLS-1:0]   write_val,
    input  logic                   step,
    input  logic                   run_enb,
    input  logic                   halt_on_stable,
    output logic [ROWS*COLS-1:0]   alive,
    output logic [GEN_W-1:0]       generation,
    output logic                   step_done,
    output logic                   stable,
    output logic                   extinct,
    output logic [1:0]             state
);

    localparam int                   CELLS      = ROWS * COLS;
    localparam int                   TIMER_W    = $clog2(PERIOD);
    localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t               r_state;
    logic [CELLS-1:0]     r_alive;
    logic [GEN_W-1:0]     r_gen;
    logic                 r_done;
    logic                 r_stable;
    logic [TIMER_W-1:0]   r_timer;

    logic [CELLS-1:0]     w_next;
    logic                 w_load;
    logic                 w_expire;
    logic                 w_take;
    logic                 w_next_same;
    logic                 w_next_dead;

    // Per-cell next state: gather the 3x3 window (centre excluded), count, apply B3/S23.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [8:0] w_win;
            logic [3:0] w_cnt;
            for (genvar k = 0; k < 9; k++) begin : g_nb
                localparam int  RR     = r + (k / 3) - 1;
                localparam int  CC     = c + (k % 3) - 1;
                localparam bit  INSIDE = (RR >= 0) && (RR < ROWS) && (CC >= 0) && (CC < COLS);
                localparam int  WR     = (RR + ROWS) % ROWS;
                localparam int  WC     = (CC + COLS) % COLS;
                if (k == 4) begin : g_centre
                    assign w_win[k] = 1'b0;
                end else if (INSIDE || (WRAP != 0)) begin : g_live
                    assign w_win[k] = r_alive[WR*COLS + WC];
                end else begin : g_dead
                    assign w_win[k] = 1'b0;
                end
            end
            assign w_cnt = 4'($countones(w_win));
            assign w_next[r*COLS + c] = (w_cnt == 4'd3) ||
                                        (r_alive[r*COLS + c] && (w_cnt == 4'd2));
        end
    end

    // A load or clear pre-empts any step, whether requested or timer-driven.
    assign w_load      = clear | write_enb;
    assign w_expire    = (r_state == ST_RUN) && run_enb && (r_timer == TIMER_LAST);
    assign w_take      = !w_load && (((r_state == ST_IDLE) && step) || w_expire);
    assign w_next_same = (w_next == r_alive);
    assign w_next_dead = ~|w_next;

    // Grid, generation counter, status flags, timer and run-control FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_alive  <= '0;
            r_gen    <= '0;
            r_done   <= 1'b0;
            r_stable <= 1'b0;
            r_timer  <= '0;
        end else begin
            r_done <= 1'b0;

            if (clear) begin
                r_alive  <= '0;
                r_gen    <= '0;
                r_stable <= 1'b0;
            end else if (write_enb) begin
                r_alive  <= write_val;
                r_gen    <= '0;
                r_stable <= 1'b0;
            end else if (w_take) begin
                r_alive  <= w_next;
                r_gen    <= r_gen + GEN_W'(1);
                r_stable <= w_next_same;
                r_done   <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (run_enb) begin
                        r_state <= ST_RUN;
                        r_timer <= '0;
                    end
                end
                ST_RUN: begin
                    if (!run_enb) begin
                        r_state <= ST_IDLE;
                        r_timer <= '0;
                    end else begin
                        if (w_load || (r_timer == TIMER_LAST)) begin
                            r_timer <= '0;
                        end else begin
                            r_timer <= r_timer + TIMER_W'(1);
                        end
                        if (w_take && halt_on_stable && (w_next_same || w_next_dead)) begin
                            r_state <= ST_HALT;
                        end
                    end
                end
                ST_HALT: begin
                    r_timer <= '0;
                    if (!run_enb) begin
                        r_state <= ST_IDLE;
                    end else if (w_load) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_timer <= '0;
                end
            endcase
        end
    end

    assign alive      = r_alive;
    assign generation = r_gen;
    assign step_done  = r_done;
    assign stable     = r_stable;
    assign extinct    = ~|r_alive;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_life_grid_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_life_grid_engine
//  Description : Self-checking bench for life_grid_engine. Four instances
//                (8x8 wrap, 8x8 wrap with 4-bit generation, 8x8 no-wrap,
//                5x5 wrap) share one set of controls and are compared every
//                cycle against a behavioural Life model, plus literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_life_grid_engine;

    localparam int N_INST = 4;
    localparam int PER    = 4;

    logic        clk            = 1'b0;
    logic        reset          = 1'b1;
    logic        clear          = 1'b0;
    logic        write_enb      = 1'b0;
    logic        step           = 1'b0;
    logic        run_enb        = 1'b0;
    logic        halt_on_stable = 1'b0;
    logic [63:0] wv             = '0;

    logic [63:0] alive_a, alive_b, alive_c;
    logic [24:0] alive_d;
    logic [15:0] gen_a, gen_c, gen_d;
    logic [3:0]  gen_b;
    logic        done_a, done_b, done_c, done_d;
    logic        stable_a, stable_b, stable_c, stable_d;
    logic        ext_a, ext_b, ext_c, ext_d;
    logic [1:0]  state_a, state_b, state_c, state_d;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    life_grid_engine #(.ROWS(8), .COLS(8), .WRAP(1), .PERIOD(PER), .GEN_W(16)) u_dut_a (
        .clk(clk), .reset(reset), .clear(clear), .write_enb(write_enb), .write_val(wv),
        .step(step), .run_enb(run_enb), .halt_on_stable(halt_on_stable),
        .alive(alive_a), .generation(gen_a), .step_done(done_a), .stable(stable_a),
        .extinct(ext_a), .state(state_a));

    life_grid_engine #(.ROWS(8), .COLS(8), .WRAP(1), .PERIOD(PER), .GEN_W(4)) u_dut_b (
        .clk(clk), .reset(reset), .clear(clear), .write_enb(write_enb), .write_val(wv),
        .step(step), .run_enb(run_enb), .halt_on_stable(halt_on_stable),
        .alive(alive_b), .generation(gen_b), .step_done(done_b), .stable(stable_b),
        .extinct(ext_b), .state(state_b));

    life_grid_engine #(.ROWS(8), .COLS(8), .WRAP(0), .PERIOD(PER), .GEN_W(16)) u_dut_c (
        .clk(clk), .reset(reset), .clear(clear), .write_enb(write_enb), .write_val(wv),
        .step(step), .run_enb(run_enb), .halt_on_stable(halt_on_stable),
        .alive(alive_c), .generation(gen_c), .step_done(done_c), .stable(stable_c),
        .extinct(ext_c), .state(state_c));

    life_grid_engine #(.ROWS(5), .COLS(5), .WRAP(1), .PERIOD(PER), .GEN_W(16)) u_dut_d (
        .clk(clk), .reset(reset), .clear(clear), .write_enb(write_enb), .write_val(wv[24:0]),
        .step(step), .run_enb(run_enb), .halt_on_stable(halt_on_stable),
        .alive(alive_d), .generation(gen_d), .step_done(done_d), .stable(stable_d),
        .extinct(ext_d), .state(state_d));

    // Uniform views of the four instances for the per-cycle compare.
    logic [63:0] d_alive [N_INST];
    logic [15:0] d_gen   [N_INST];
    logic        d_done  [N_INST];
    logic        d_stab  [N_INST];
    logic        d_ext   [N_INST];
    logic [1:0]  d_state [N_INST];

    assign d_alive[0] = alive_a;            assign d_alive[1] = alive_b;
    assign d_alive[2] = alive_c;            assign d_alive[3] = {39'b0, alive_d};
    assign d_gen[0]   = gen_a;              assign d_gen[1]   = {12'b0, gen_b};
    assign d_gen[2]   = gen_c;              assign d_gen[3]   = gen_d;
    assign d_done[0]  = done_a;             assign d_done[1]  = done_b;
    assign d_done[2]  = done_c;             assign d_done[3]  = done_d;
    assign d_stab[0]  = stable_a;           assign d_stab[1]  = stable_b;
    assign d_stab[2]  = stable_c;           assign d_stab[3]  = stable_d;
    assign d_ext[0]   = ext_a;              assign d_ext[1]   = ext_b;
    assign d_ext[2]   = ext_c;              assign d_ext[3]   = ext_d;
    assign d_state[0] = state_a;            assign d_state[1] = state_b;
    assign d_state[2] = state_c;            assign d_state[3] = state_d;

    function automatic int cfg_rows(input int i); return (i == 3) ? 5 : 8; endfunction
    function automatic int cfg_cols(input int i); return (i == 3) ? 5 : 8; endfunction
    function automatic bit cfg_wrap(input int i); return (i != 2); endfunction
    function automatic int cfg_genw(input int i); return (i == 1) ? 4 : 16; endfunction

    // Reference Life rule: count the eight neighbours of every cell directly.
    function automatic logic [63:0] life_next(input logic [63:0] g, input int rows,
                                              input int cols, input bit wrap);
        logic [63:0] n;
        int cnt, rr, cc;
        n = '0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (dr == 0 && dc == 0) continue;
                        if (wrap) begin
                            rr = (rr + rows) % rows;
                            cc = (cc + cols) % cols;
                        end else if (rr < 0 || rr >= rows || cc < 0 || cc >= cols) begin
                            continue;
                        end
                        cnt += int'(g[rr*cols + cc]);
                    end
                end
                n[r*cols + c] = (cnt == 3) || (g[r*cols + c] && cnt == 2);
            end
        end
        return n;
    endfunction

    // Model state per instance (state: 0 idle, 1 run, 2 halt).
    logic [63:0] m_alive [N_INST];
    int          m_gen   [N_INST];
    bit          m_done  [N_INST];
    bit          m_stab  [N_INST];
    int          m_state [N_INST];
    int          m_timer [N_INST];

    task automatic model_edge(input int i);
        int          cells;
        logic [63:0] mask;
        logic [63:0] nxt;
        bit          load;
        bit          take;
        int          old_state;
        cells     = cfg_rows(i) * cfg_cols(i);
        mask      = (cells == 64) ? '1 : ((64'd1 << cells) - 64'd1);
        nxt       = life_next(m_alive[i], cfg_rows(i), cfg_cols(i), cfg_wrap(i));
        load      = clear || write_enb;
        take      = 1'b0;
        old_state = m_state[i];
        m_done[i] = 1'b0;
        if (old_state == 0) begin
            take = step && !load;
            if (run_enb) begin m_state[i] = 1; m_timer[i] = 0; end
        end else if (old_state == 1) begin
            if (!run_enb) begin
                m_state[i] = 0; m_timer[i] = 0;
            end else if (m_timer[i] == PER - 1) begin
                take = !load; m_timer[i] = 0;
            end else begin
                m_timer[i] = load ? 0 : m_timer[i] + 1;
            end
        end else begin
            m_timer[i] = 0;
            if (!run_enb) m_state[i] = 0;
            else if (load) m_state[i] = 1;
        end
        if (clear) begin
            m_alive[i] = '0; m_gen[i] = 0; m_stab[i] = 1'b0;
        end else if (write_enb) begin
            m_alive[i] = wv & mask; m_gen[i] = 0; m_stab[i] = 1'b0;
        end else if (take) begin
            m_stab[i]  = (nxt == m_alive[i]);
            m_alive[i] = nxt;
            m_gen[i]   = (m_gen[i] + 1) % (1 << cfg_genw(i));
            m_done[i]  = 1'b1;
            if (old_state == 1 && halt_on_stable && (m_stab[i] || nxt == '0)) m_state[i] = 2;
        end
    endtask

    // Behavioural model advances on the same edges as the DUTs.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_INST; i++) begin
                m_alive[i] = '0; m_gen[i] = 0; m_done[i] = 1'b0;
                m_stab[i]  = 1'b0; m_state[i] = 0; m_timer[i] = 0;
            end
        end else begin
            for (int i = 0; i < N_INST; i++) model_edge(i);
        end
    end

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic compare_all();
        for (int i = 0; i < N_INST; i++) begin
            check_val($sformatf("alive[%0d]", i),  d_alive[i],        m_alive[i]);
            check_val($sformatf("gen[%0d]", i),    64'(d_gen[i]),     64'(m_gen[i]));
            check_val($sformatf("done[%0d]", i),   64'(d_done[i]),    64'(m_done[i]));
            check_val($sformatf("stable[%0d]", i), 64'(d_stab[i]),    64'(m_stab[i]));
            check_val($sformatf("extinct[%0d]", i), 64'(d_ext[i]),    64'(m_alive[i] == '0));
            check_val($sformatf("state[%0d]", i),  64'(d_state[i]),   64'(m_state[i]));
        end
    endtask

    // One clock: let the edge happen, then compare on the falling edge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic load(input logic [63:0] pat);
        wv = pat; write_enb = 1'b1; cycle(); write_enb = 1'b0;
    endtask

    task automatic single_step();
        step = 1'b1; cycle(); step = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b0;
        cycle(); cycle();
        check_val("reset_alive", alive_a, 64'h0);
        check_val("reset_state", 64'(state_a), 64'h0);
        reset = 1'b1;
        cycle();

        // Horizontal blinker on the 5x5 turns vertical.
        load(64'h3800);
        single_step();
        check_val("blink_alive_5x5", 64'(alive_d), 64'h21080);
        check_val("blink_done_5x5", 64'(done_d), 64'h1);
        check_val("blink_gen_5x5", 64'(gen_d), 64'h1);
        check_val("blink_stable_5x5", 64'(stable_d), 64'h0);

        // Lone cell dies.
        load(64'h1000);
        single_step();
        check_val("lone_alive", alive_a, 64'h0);
        check_val("lone_extinct", 64'(ext_a), 64'h1);

        // Edge blinker: wrap keeps the cell on row 7, no-wrap loses it.
        load(64'h7);
        single_step();
        check_val("edge_nowrap", alive_c, 64'h0000_0000_0000_0202);
        check_val("edge_wrap", alive_a, 64'h0200_0000_0000_0202);

        // Glider: 32 consecutive steps return it home on the torus.
        load(64'h70402);
        step = 1'b1;
        repeat (32) cycle();
        step = 1'b0;
        check_val("glider_alive", alive_a, 64'h70402);
        check_val("glider_gen16", 64'(gen_a), 64'd32);
        check_val("glider_gen4", 64'(gen_b), 64'd0);
        check_val("glider_alive_g4", alive_b, 64'h70402);

        // Still-life block while free-running halts after one step.
        halt_on_stable = 1'b1;
        load(64'h0000_0018_1800_0000);
        run_enb = 1'b1;
        repeat (20) cycle();
        check_val("block_gen", 64'(gen_a), 64'd1);
        check_val("block_state", 64'(state_a), 64'd2);
        check_val("block_stable", 64'(stable_a), 64'd1);
        load(64'h3800);
        check_val("halt_reload_run", 64'(state_a), 64'd1);
        clear = 1'b1; cycle(); clear = 1'b0;
        check_val("clear_alive", alive_a, 64'h0);
        run_enb = 1'b0; halt_on_stable = 1'b0;
        cycle();

        // Reset mid-run, then a load that lands on timer expiry.
        load(64'h3800);
        run_enb = 1'b1;
        repeat (6) cycle();
        #2 reset = 1'b0;
        #1;
        check_val("midreset_alive", alive_a, 64'h0);
        check_val("midreset_gen", 64'(gen_a), 64'h0);
        check_val("midreset_state", 64'(state_a), 64'h0);
        check_val("midreset_done", 64'(done_a), 64'h0);
        cycle();
        reset = 1'b1;
        repeat (4) cycle();
        load(64'h00FF);
        check_val("expiry_load_alive", alive_a, 64'h00FF);
        check_val("expiry_load_done", 64'(done_a), 64'h0);
        check_val("expiry_load_gen", 64'(gen_a), 64'h0);
        repeat (4) cycle();
        check_val("after_load_step", 64'(done_a), 64'h1);
        run_enb = 1'b0;
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
